// File: rtl/bound_flasher_monitor.sv
// Passive checker for the 16-bit bound-flasher LED bus: decodes the thermometer
// pattern into flasher phase and reports kickbacks, completed cycles and violations.
module bound_flasher_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      leds,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             in_sync,
  output logic             kickback,
  output logic             cycle_done,
  output logic             err,
  output logic             err_sticky,
  output logic [2:0]       err_phase,
  output logic [4:0]       lit_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] kick_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UP5   = 3'd1,
    DN0A  = 3'd2,
    UP10  = 3'd3,
    DN5   = 3'd4,
    UP15  = 3'd5,
    DN0B  = 3'd6,
    BLINK = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  phase_t      state, state_nxt;
  logic [15:0] cur, prev;
  logic        grow, shrink, hold;
  logic        bad, kick_nxt, done_nxt, sync_nxt, err_nxt;

  assign grow   = (cur == {prev[14:0], 1'b1});
  assign shrink = (cur == {1'b0, prev[15:1]});
  assign hold   = (cur == prev);
  assign phase  = state;

  always_comb begin
    state_nxt = state;
    bad       = 1'b0;
    kick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    sync_nxt  = in_sync;
    // Outside IDLE the bus must move every clock, so any hold is a violation.
    if (state != IDLE && hold) begin
      bad = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cur == '0)                         sync_nxt = 1'b1;
          else if (prev == '0 && cur == 16'h0001) state_nxt = UP5;
          else                                    bad = 1'b1;
        end
        UP5: begin
          if (grow) begin
            if (cur == 16'h003F) state_nxt = DN0A;
          end else bad = 1'b1;
        end
        DN0A: begin
          if (shrink) begin
            if (cur == '0) state_nxt = UP10;
          end else bad = 1'b1;
        end
        UP10: begin
          if (grow) begin
            if (cur == 16'h07FF) state_nxt = DN5;
          end else if (shrink && prev == 16'h003F) begin
            state_nxt = DN0A;
            kick_nxt  = 1'b1;
          end else bad = 1'b1;
        end
        DN5: begin
          // 0x1F is the turning point: grow climbs to UP15, shrink is a flick back to 0.
          if (prev == 16'h001F) begin
            if (grow) state_nxt = UP15;
            else if (shrink) begin
              state_nxt = DN0A;
              kick_nxt  = 1'b1;
            end else bad = 1'b1;
          end else if (!shrink) bad = 1'b1;
        end
        UP15: begin
          if (grow) begin
            if (cur == 16'hFFFF) state_nxt = DN0B;
          end else if (shrink && (prev == 16'h003F || prev == 16'h07FF)) begin
            state_nxt = DN5;
            kick_nxt  = 1'b1;
          end else bad = 1'b1;
        end
        DN0B: begin
          if (shrink) begin
            if (cur == '0) state_nxt = BLINK;
          end else bad = 1'b1;
        end
        BLINK: begin
          if (prev == '0 && cur == 16'hFFFF) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      state_nxt = IDLE;
      sync_nxt  = 1'b0;
    end
    err_nxt = bad && in_sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      prev        <= '0;
      in_sync     <= 1'b0;
      kickback    <= 1'b0;
      cycle_done  <= 1'b0;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      err_phase   <= '0;
      lit_count   <= '0;
      cycle_count <= '0;
      kick_count  <= '0;
    end else begin
      state      <= state_nxt;
      cur        <= leds;
      prev       <= cur;
      in_sync    <= sync_nxt;
      kickback   <= kick_nxt;
      cycle_done <= done_nxt;
      err        <= err_nxt;
      lit_count  <= 5'($countones(leds));
      // A fresh error outranks a simultaneous clear.
      if (err_nxt) begin
        err_sticky <= 1'b1;
        err_phase  <= state;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_phase  <= '0;
      end
      if (done_nxt && cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
      if (kick_nxt && kick_count != CNT_MAX)  kick_count  <= kick_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Bench for bound_flasher_monitor: directed flasher cycles plus randomized glitches,
// clears and resets, checked every cycle against a phase-rule model.
module tb_bound_flasher_monitor;

  logic        clk = 1'b0;
  logic        rst, clr_err;
  logic [15:0] leds;

  logic [2:0] a_phase, a_err_phase, b_phase, b_err_phase;
  logic       a_in_sync, a_kickback, a_cycle_done, a_err, a_err_sticky;
  logic       b_in_sync, b_kickback, b_cycle_done, b_err, b_err_sticky;
  logic [4:0] a_lit_count, b_lit_count;
  logic [7:0] a_cycle_count, a_kick_count;
  logic [1:0] b_cycle_count, b_kick_count;

  always #5 clk = ~clk;

  bound_flasher_monitor #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .leds(leds), .clr_err(clr_err),
    .phase(a_phase), .in_sync(a_in_sync), .kickback(a_kickback),
    .cycle_done(a_cycle_done), .err(a_err), .err_sticky(a_err_sticky),
    .err_phase(a_err_phase), .lit_count(a_lit_count),
    .cycle_count(a_cycle_count), .kick_count(a_kick_count)
  );

  bound_flasher_monitor #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .leds(leds), .clr_err(clr_err),
    .phase(b_phase), .in_sync(b_in_sync), .kickback(b_kickback),
    .cycle_done(b_cycle_done), .err(b_err), .err_sticky(b_err_sticky),
    .err_phase(b_err_phase), .lit_count(b_lit_count),
    .cycle_count(b_cycle_count), .kick_count(b_kick_count)
  );

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;
  bit rnd_on = 1'b0;
  bit want_clr = 1'b0;
  int glitch_cnt = 0;
  int b_done_seen = 0;

  // Behavioural model state
  int          m_ph = 0, m_eph = 0, m_lit = 0, m_cyc = 0, m_kc = 0;
  bit          m_sync = 0, m_kick = 0, m_done = 0, m_err = 0, m_sticky = 0;
  logic [15:0] m_cur = '0, m_prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Judge the step prev->cur against the phase rules: up phases grow toward a top
  // value, down phases shrink toward a bottom, with listed reversals as kickbacks.
  task automatic model_step();
    logic [15:0] g, s, top;
    int nxt, idx;
    bit bad, k, d, ns;
    g = {m_prev[14:0], 1'b1};
    s = m_prev >> 1;
    nxt = m_ph; bad = 0; k = 0; d = 0; ns = m_sync;
    if (m_ph == 0) begin
      if (m_cur == 0) ns = 1;
      else if (m_prev == 0 && m_cur == 16'h0001) nxt = 1;
      else bad = 1;
    end else if (m_cur == m_prev) begin
      bad = 1;
    end else if (m_ph == 7) begin
      if (m_prev == 0 && m_cur == 16'hFFFF) begin nxt = 0; d = 1; end
      else bad = 1;
    end else if (m_ph % 2 == 1) begin
      idx = m_ph / 2;
      top = (idx == 0) ? 16'h003F : (idx == 1) ? 16'h07FF : 16'hFFFF;
      if (m_cur == g) nxt = (m_cur == top) ? m_ph + 1 : m_ph;
      else if (m_cur == s && ((idx >= 1 && m_prev == 16'h003F) || (idx == 2 && m_prev == 16'h07FF))) begin
        nxt = m_ph - 1; k = 1;
      end else bad = 1;
    end else if (m_ph == 4 && m_prev == 16'h001F) begin
      if (m_cur == g) nxt = 5;
      else if (m_cur == s) begin nxt = 2; k = 1; end
      else bad = 1;
    end else begin
      if (m_cur != s) bad = 1;
      else if (m_ph != 4 && m_cur == 0) nxt = m_ph + 1;
    end
    m_err = bad && m_sync;
    m_kick = k;
    m_done = d;
    if (m_err) begin m_sticky = 1; m_eph = m_ph; end
    else if (clr_err) begin m_sticky = 0; m_eph = 0; end
    if (bad) begin nxt = 0; ns = 0; end
    m_ph = nxt;
    m_sync = ns;
    m_cyc += d;
    m_kc += k;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_eph = 0; m_lit = 0; m_cyc = 0; m_kc = 0;
      m_sync = 0; m_kick = 0; m_done = 0; m_err = 0; m_sticky = 0;
      m_cur = '0; m_prev = '0;
    end else begin
      model_step();
      m_prev = m_cur;
      m_cur = leds;
      m_lit = $countones(leds);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("phase", 32'(a_phase), m_ph);
      chk("in_sync", 32'(a_in_sync), 32'(m_sync));
      chk("kickback", 32'(a_kickback), 32'(m_kick));
      chk("cycle_done", 32'(a_cycle_done), 32'(m_done));
      chk("err", 32'(a_err), 32'(m_err));
      chk("err_sticky", 32'(a_err_sticky), 32'(m_sticky));
      chk("err_phase", 32'(a_err_phase), m_eph);
      chk("lit_count", 32'(a_lit_count), m_lit);
      chk("cycle_count", 32'(a_cycle_count), sat(m_cyc, 255));
      chk("kick_count", 32'(a_kick_count), sat(m_kc, 255));
      chk("cycle_count_w2", 32'(b_cycle_count), sat(m_cyc, 3));
      chk("kick_count_w2", 32'(b_kick_count), sat(m_kc, 3));
      chk("cycle_done_w2", 32'(b_cycle_done), 32'(m_done));
      if (b_cycle_done) b_done_seen++;
    end
  end

  task automatic drive(input logic [15:0] v);
    leds = v;
    rst = 1'b0;
    clr_err = want_clr;
    want_clr = 1'b0;
    if (rnd_on) begin
      if (glitch_cnt > 0) begin
        glitch_cnt--;
        if (glitch_cnt == 0) leds = 16'($urandom);
      end
      if ($urandom_range(15) == 0) clr_err = 1'b1;
      if ($urandom_range(299) == 0) rst = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic up(input logic [15:0] from, input logic [15:0] to);
    logic [15:0] v;
    v = from;
    while (v != to) begin
      v = {v[14:0], 1'b1};
      drive(v);
    end
  endtask

  task automatic dn(input logic [15:0] from, input logic [15:0] to);
    logic [15:0] v;
    v = from;
    while (v != to) begin
      v = v >> 1;
      drive(v);
    end
  endtask

  task automatic do_rst();
    leds = 16'h07FF;
    clr_err = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // k15: 0 none, 1 reversal at 0x7FF, 2 reversal at 0x3F
  task automatic cycle(input bit k10, input bit kdn5, input int k15);
    drive(16'h0000);
    up(16'h0000, 16'h003F);
    dn(16'h003F, 16'h0000);
    if (k10) begin up(16'h0000, 16'h003F); dn(16'h003F, 16'h0000); end
    up(16'h0000, 16'h07FF);
    dn(16'h07FF, 16'h001F);
    if (kdn5) begin dn(16'h001F, 16'h0000); up(16'h0000, 16'h07FF); dn(16'h07FF, 16'h001F); end
    if (k15 == 1) begin up(16'h001F, 16'h07FF); dn(16'h07FF, 16'h001F); end
    else if (k15 == 2) begin up(16'h001F, 16'h003F); dn(16'h003F, 16'h001F); end
    up(16'h001F, 16'hFFFF);
    dn(16'hFFFF, 16'h0000);
    drive(16'hFFFF);
    drive(16'h0000);
  endtask

  initial begin
    rst = 1'b1; leds = '0; clr_err = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    started = 1'b1;
    chk("rst_phase", 32'(a_phase), 0);
    chk("rst_in_sync", 32'(a_in_sync), 0);
    chk("rst_lit", 32'(a_lit_count), 0);
    chk("rst_cycles", 32'(a_cycle_count), 0);

    // Nominal cycle
    drive(16'h0000); drive(16'h0000); drive(16'h0000);
    cycle(0, 0, 0);
    chk("nom_done", 32'(a_cycle_done), 1);
    chk("nom_cycles", 32'(a_cycle_count), 1);
    chk("nom_model_cycles", m_cyc, 1);
    chk("nom_sticky", 32'(a_err_sticky), 0);

    // UP10 kickback
    drive(16'h0000);
    up(16'h0000, 16'h003F); dn(16'h003F, 16'h0000); up(16'h0000, 16'h003F);
    drive(16'h001F); drive(16'h000F);
    chk("k10_pulse", 32'(a_kickback), 1);
    chk("k10_phase", 32'(a_phase), 2);
    chk("k10_count", 32'(a_kick_count), 1);
    dn(16'h000F, 16'h0000); drive(16'h0001); drive(16'h0003);
    chk("k10_reenter", 32'(a_phase), 3);
    up(16'h0003, 16'h07FF); dn(16'h07FF, 16'h001F); up(16'h001F, 16'hFFFF);
    dn(16'hFFFF, 16'h0000); drive(16'hFFFF); drive(16'h0000);

    // UP15 kickback at 0x7FF
    drive(16'h0000);
    up(16'h0000, 16'h003F); dn(16'h003F, 16'h0000); up(16'h0000, 16'h07FF);
    dn(16'h07FF, 16'h001F); up(16'h001F, 16'h07FF);
    drive(16'h03FF); drive(16'h01FF);
    chk("k15_pulse", 32'(a_kickback), 1);
    chk("k15_phase", 32'(a_phase), 4);
    dn(16'h01FF, 16'h001F); drive(16'h003F); drive(16'h007F);
    chk("k15_regrow", 32'(a_phase), 5);
    up(16'h007F, 16'hFFFF); dn(16'hFFFF, 16'h0000); drive(16'hFFFF); drive(16'h0000);

    // UP15 kickback at 0x3F
    cycle(0, 0, 2);
    chk("k15b_kicks", 32'(a_kick_count), 3);
    chk("k15b_cycles", 32'(a_cycle_count), 4);

    // Violation in UP5
    drive(16'h0000); up(16'h0000, 16'h0007);
    drive(16'h0005); drive(16'h1234);
    chk("viol_err", 32'(a_err), 1);
    chk("viol_err_phase", 32'(a_err_phase), 1);
    chk("viol_in_sync", 32'(a_in_sync), 0);
    chk("viol_phase", 32'(a_phase), 0);
    drive(16'hBEEF); drive(16'h0F0F);
    chk("viol_quiet", 32'(a_err), 0);
    chk("viol_sticky", 32'(a_err_sticky), 1);
    drive(16'h0000); drive(16'h0000);
    chk("viol_resync", 32'(a_in_sync), 1);
    want_clr = 1'b1;
    drive(16'h0000);
    chk("viol_clr", 32'(a_err_sticky), 0);

    // Reset in DN0B at 0x0FFF
    drive(16'h0000);
    up(16'h0000, 16'h003F); dn(16'h003F, 16'h0000); up(16'h0000, 16'h07FF);
    dn(16'h07FF, 16'h001F); up(16'h001F, 16'hFFFF); dn(16'hFFFF, 16'h0FFF);
    chk("pre_rst_phase", 32'(a_phase), 6);
    do_rst();
    b_done_seen = 0;
    chk("mrst_phase", 32'(a_phase), 0);
    chk("mrst_in_sync", 32'(a_in_sync), 0);
    chk("mrst_lit", 32'(a_lit_count), 0);
    chk("mrst_cycles", 32'(a_cycle_count), 0);
    chk("mrst_kicks", 32'(a_kick_count), 0);
    chk("mrst_sticky", 32'(a_err_sticky), 0);
    cycle(0, 0, 0);
    chk("mrst_clean", 32'(a_cycle_count), 1);
    chk("mrst_clean_sticky", 32'(a_err_sticky), 0);

    // Saturation of the 2-bit instance
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    drive(16'h0000);
    chk("sat_w2", 32'(b_cycle_count), 3);
    chk("sat_w8", 32'(a_cycle_count), 5);
    chk("sat_pulses", b_done_seen, 5);

    // Randomized cycles with glitches, clears and resets
    rnd_on = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) glitch_cnt = $urandom_range(60, 1);
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(2));
    end
    rnd_on = 1'b0;
    glitch_cnt = 0;
    drive(16'h0000); drive(16'h0000); drive(16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
